// File: rtl/fifo_memory_pkg.sv
// Shared defaults and parameter derivations for the width-converting FIFO.
package fifo_memory_pkg;

  localparam int unsigned DEF_DATA_IN_WIDTH  = 16;
  localparam int unsigned DEF_DATA_OUT_WIDTH = 4;
  localparam int unsigned DEF_DEPTH          = 8;

  // Number of output slices carried by one input word.
  function automatic int unsigned ratio_of(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Index width for a range of n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_memory_ram.sv
// Word storage: one synchronous write port, one asynchronous read port.
module fifo_memory_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_memory_dw.sv
// Width-converting FIFO: wide words in, narrow slices out, MS slice first.
module fifo_memory_dw
  import fifo_memory_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int unsigned DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
  parameter int unsigned DEPTH          = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned RATIO = ratio_of(DATA_IN_WIDTH, DATA_OUT_WIDTH);
  localparam int unsigned PW    = idx_width(DEPTH);
  localparam int unsigned SW    = idx_width(RATIO);
  localparam int unsigned CW    = PW + 1;

  if (DATA_IN_WIDTH % DATA_OUT_WIDTH != 0) begin : g_bad_ratio
    $error("fifo_memory_dw: DATA_IN_WIDTH must be a multiple of DATA_OUT_WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_memory_dw: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0]            wp, rp;
  logic [CW-1:0]            cnt;
  logic [SW-1:0]            si;
  logic [DATA_IN_WIDTH-1:0] rd_word;
  logic [DATA_IN_WIDTH-1:0] shifted;
  int unsigned              shift_amt;
  logic                     wr_ok, rd_ok, last_slice, retire;

  assign empty      = (cnt == '0);
  assign full       = (cnt == CW'(DEPTH));
  assign wr_ok      = wr_en && !full;
  assign rd_ok      = rd_en && !empty;
  assign last_slice = (si == SW'(RATIO - 1));
  assign retire     = rd_ok && last_slice;

  fifo_memory_ram #(
    .WIDTH (DATA_IN_WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wp),
    .wr_data (data_in),
    .rd_addr (rp),
    .rd_data (rd_word)
  );

  // Select slice si by shifting it into the top of the word.
  always_comb begin
    shift_amt = int'(si) * DATA_OUT_WIDTH;
    shifted   = rd_word << shift_amt;
  end

  // Pointers, word count, slice index and registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      si       <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) begin
        data_out <= shifted[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];
        if (last_slice) begin
          si <= '0;
          rp <= rp + 1'b1;
        end else begin
          si <= si + 1'b1;
        end
      end
      // A word is only freed once its final slice leaves.
      case ({wr_ok, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_memory_dw.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_fifo_memory_dw;

  localparam int IW    = 16;
  localparam int OW    = 4;
  localparam int DEPTH = 8;
  localparam int RATIO = IW / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [IW-1:0] data_in;
  logic [OW-1:0] data_out;
  logic          empty, full;

  int n_err    = 0;
  int n_checks = 0;

  // Reference model: queue of whole words plus the index of the next slice.
  logic [IW-1:0] q[$];
  int            msi      = 0;
  logic [OW-1:0] exp_dout = '0;
  string         phase    = "init";

  fifo_memory_dw #(
    .DATA_IN_WIDTH  (IW),
    .DATA_OUT_WIDTH (OW),
    .DEPTH          (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", phase, tag, got, exp, $time);
    end
  endtask

  // One clock edge of the model, evaluated against pre-edge occupancy.
  task automatic model_edge(input logic wr, input logic rd, input logic [IW-1:0] din);
    bit was_empty = (q.size() == 0);
    bit was_full  = (q.size() == DEPTH);
    if (rd && !was_empty) begin
      exp_dout = OW'(q[0] >> ((RATIO - 1 - msi) * OW));
      msi++;
      if (msi == RATIO) begin
        void'(q.pop_front());
        msi = 0;
      end
    end
    if (wr && !was_full) q.push_back(din);
  endtask

  task automatic step(input logic wr, input logic rd, input logic [IW-1:0] din);
    @(negedge clk);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    model_edge(wr, rd, din);
    #1;
    check("data_out", 32'(data_out), 32'(exp_dout));
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("full",     32'(full),     32'(q.size() == DEPTH));
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0) && (guard < 200)) begin
      step(1'b0, 1'b1, '0);
      guard++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("data_out", 32'(data_out), 32'd0);
    check("empty", 32'(empty), 32'd1);
    check("full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, '0);

    phase = "basic";
    step(1'b1, 1'b0, 16'hABCD);
    step(1'b1, 1'b0, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      logic [IW-1:0] golden0 = 16'hABCD;
      logic [IW-1:0] golden1 = 16'h1234;
      logic [IW-1:0] w;
      step(1'b0, 1'b1, '0);
      w = (i < 4) ? golden0 : golden1;
      check($sformatf("slice%0d", i), 32'(data_out), 32'(OW'(w >> ((3 - (i % 4)) * OW))));
    end
    check("empty_after8", 32'(empty), 32'd1);
    step(1'b0, 1'b1, '0);
    check("hold_after_empty", 32'(data_out), 32'h4);

    phase = "full";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, IW'(i));
    check("full_set", 32'(full), 32'd1);
    step(1'b1, 1'b0, 16'hFFFF);
    check("full_hold", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH * RATIO; i++) begin
      step(1'b0, 1'b1, '0);
      check($sformatf("drain%0d", i), 32'(data_out), ((i % RATIO) == RATIO - 1) ? 32'(i / RATIO) : 32'd0);
    end
    check("empty_after_drain", 32'(empty), 32'd1);

    phase = "partial";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, IW'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    check("full_partial", 32'(full), 32'd1);
    step(1'b0, 1'b1, '0);
    check("full_retired", 32'(full), 32'd0);
    drain();

    phase = "concurrent";
    step(1'b1, 1'b0, 16'hAFE9);
    step(1'b1, 1'b0, 16'h8765);
    for (int i = 0; i < 8 * RATIO; i++) step(1'b1, 1'b1, IW'($urandom));
    drain();

    phase = "random";
    for (int blk = 0; blk < 3; blk++) begin
      int wp_pct = (blk == 0) ? 75 : (blk == 1) ? 25 : 50;
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 99) < wp_pct), ($urandom_range(0, 99) < 60), IW'($urandom));
      end
    end
    drain();

    phase = "midreset";
    step(1'b1, 1'b0, 16'hABCD);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    check("pre_reset_slice", 32'(data_out), 32'hB);
    #1;
    rst = 1'b0;
    #1;
    q.delete();
    msi      = 0;
    exp_dout = '0;
    check("async_data_out", 32'(data_out), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_full", 32'(full), 32'd0);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h5678);
    for (int i = 0; i < RATIO; i++) begin
      step(1'b0, 1'b1, '0);
      check($sformatf("after_reset%0d", i), 32'(data_out), 32'(5 + i));
    end
    check("final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
